lcd_ctrl: RTL and testbench

- Hardware HD44780 character-LCD transmitter. It replaces software bit-banging of the pipelined core's LCD output register.
- Accepts byte writes (command or character) from the core's IO store path over a valid/ready handshake.
- Runs a power-on init sequence by itself.
- Drives the LCD pins with correct setup, enable-pulse, hold and execution-wait timing.
- Output word uses the same packing as the core's LCD register, so the existing driver/scoreboard bench checks it unchanged.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_timer.sv | 26 ++
 rtl/lcd_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD transmitter.
// Pin positions match the core's LCD output register packing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int LCD_ON = 31;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and return-home need the long execution wait on the panel.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 transmitter: self-running power-on init, then byte writes over valid/ready.
//   state     | meaning
//   INIT_WAIT | power-on delay before the first init command
//   IDLE      | ready for a write (o_ready=1)
//   SETUP     | RS/DATA stable, EN low
//   PULSE     | EN high
//   HOLD      | RS/DATA held, EN low
//   WAIT      | LCD execution time; then next init byte or IDLE
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT_CYC = 750000,
    parameter int SETUP_CYC     = 4,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 4,
    parameter int CMD_WAIT_CYC  = 2500,
    parameter int CLR_WAIT_CYC  = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    localparam int MAX_CYC = max_int(max_int(max_int(INIT_WAIT_CYC, SETUP_CYC),
                                             max_int(PULSE_CYC, HOLD_CYC)),
                                     max_int(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int TW = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] SETUP_VAL = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_VAL = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_VAL  = TW'(HOLD_CYC - 1);
    localparam logic [1:0]    INIT_LAST = 2'(INIT_LEN - 1);

    lcd_state_e    state;
    logic          init_armed;
    logic [1:0]    init_idx;
    logic          init_done_r;
    logic          on_r;
    logic          en_r;
    logic          rs_r;
    logic [7:0]    data_r;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic [TW-1:0] wait_val;
    logic          tmr_done;

    lcd_timer #(.W(TW)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_done     (tmr_done)
    );

    // The timer comes out of reset at zero, so INIT_WAIT spends its first
    // cycle arming the counter with one less than the usual N-1.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        wait_val = is_slow_cmd(rs_r, data_r) ? TW'(CLR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1);
        case (state)
            ST_INIT_WAIT: begin
                if (!init_armed) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(INIT_WAIT_CYC - 2);
                end else if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                end
            end
            ST_IDLE: begin
                if (i_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_VAL;
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_VAL;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = wait_val;
                end
            end
            ST_WAIT: begin
                if (tmr_done && !init_done_r && (init_idx != INIT_LAST)) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_INIT_WAIT;
            init_armed  <= 1'b0;
            init_idx    <= '0;
            init_done_r <= 1'b0;
            on_r        <= 1'b0;
            en_r        <= 1'b0;
            rs_r        <= 1'b0;
            data_r      <= '0;
        end else begin
            on_r <= 1'b1;
            case (state)
                ST_INIT_WAIT: begin
                    if (!init_armed) begin
                        init_armed <= 1'b1;
                    end else if (tmr_done) begin
                        init_idx <= '0;
                        rs_r     <= 1'b0;
                        data_r   <= INIT_CMDS[0];
                        state    <= ST_SETUP;
                    end
                end
                ST_IDLE: begin
                    if (i_valid) begin
                        rs_r   <= i_rs;
                        data_r <= i_data;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        en_r  <= 1'b1;
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_done) begin
                        en_r  <= 1'b0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tmr_done) begin
                        if (init_done_r) begin
                            state <= ST_IDLE;
                        end else if (init_idx == INIT_LAST) begin
                            init_done_r <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            rs_r     <= 1'b0;
                            data_r   <= INIT_CMDS[init_idx + 2'd1];
                            state    <= ST_SETUP;
                        end
                    end
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

    assign o_ready     = (state == ST_IDLE);
    assign o_init_done = init_done_r;

    always_comb begin
        o_io_lcd         = '0;
        o_io_lcd[LCD_ON] = on_r;
        o_io_lcd[LCD_EN] = en_r;
        o_io_lcd[LCD_RS] = rs_r;
        o_io_lcd[LCD_RW] = 1'b0;
        o_io_lcd[7:0]    = data_r;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;

    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int CLRW  = 40;
    localparam int INITW = 20;

    typedef struct packed {
        logic        stable;
        logic        rs;
        logic [7:0]  data;
        logic [15:0] width;
    } pulse_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_rs = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_ready;
    logic        o_init_done;
    logic [31:0] o_io_lcd;

    int checks = 0;
    int errors = 0;

    pulse_t log_q[$];
    pulse_t cur = '0;
    logic   en_q = 1'b0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .INIT_WAIT_CYC (INITW),
        .SETUP_CYC     (SETUP),
        .PULSE_CYC     (PULSE),
        .HOLD_CYC      (HOLD),
        .CMD_WAIT_CYC  (CMDW),
        .CLR_WAIT_CYC  (CLRW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_rs        (i_rs),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_init_done (o_init_done),
        .o_io_lcd    (o_io_lcd)
    );

    // EN pulse monitor: records RS/DATA at the rise, pulse width and stability.
    always @(negedge clk) begin
        if (o_io_lcd[10] && !en_q) begin
            cur <= '{stable: 1'b1, rs: o_io_lcd[9], data: o_io_lcd[7:0], width: 16'd1};
        end else if (o_io_lcd[10]) begin
            cur.width <= cur.width + 16'd1;
            if (o_io_lcd[9] !== cur.rs || o_io_lcd[7:0] !== cur.data) cur.stable <= 1'b0;
        end else if (en_q) begin
            log_q.push_back(cur);
        end
        en_q <= o_io_lcd[10];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic measure_init(output int on_first, output int first_en, output int ready_at);
        on_first = -1;
        first_en = -1;
        ready_at = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (n == 1) on_first = int'(o_io_lcd[31]);
            if (first_en < 0 && o_io_lcd[10] === 1'b1) first_en = n;
            if (o_ready === 1'b1) begin
                ready_at = n;
                break;
            end
        end
    endtask

    task automatic check_init_log();
        logic [7:0] exp_cmd [4];
        exp_cmd[0] = 8'h38;
        exp_cmd[1] = 8'h0C;
        exp_cmd[2] = 8'h01;
        exp_cmd[3] = 8'h06;
        check("init_pulse_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check($sformatf("init_pulse_%0d", i), 32'(log_q[i]),
                  32'({1'b1, 1'b0, exp_cmd[i], 16'(PULSE)}));
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int busy, output int bad);
        int   guard;
        logic exp_en;
        guard = 0;
        busy  = 0;
        bad   = 0;
        while (o_ready !== 1'b1 && guard < 500) begin
            tick();
            guard++;
        end
        i_valid = 1'b1;
        i_rs    = rs;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        i_rs    = ~rs;
        i_data  = ~d;
        while (o_ready !== 1'b1 && busy < 500) begin
            exp_en = (busy >= SETUP) && (busy < SETUP + PULSE);
            if (o_io_lcd[10] !== exp_en || o_io_lcd[9] !== rs || o_io_lcd[7:0] !== d ||
                o_io_lcd[31] !== 1'b1 || o_io_lcd[8] !== 1'b0 || o_io_lcd[30:11] !== '0) bad++;
            busy++;
            tick();
        end
    endtask

    initial begin
        int on_first, first_en, ready_at, busy, bad, guard, accepted, mism;
        logic [8:0] exp_q[$];
        logic       v;
        logic       r_rs;
        logic [7:0] r_d;

        repeat (3) tick();
        check("reset_io_lcd", o_io_lcd, 32'h0);
        check("reset_ready", 32'(o_ready), 32'h0);
        check("reset_init_done", 32'(o_init_done), 32'h0);

        i_reset = 1'b1;
        measure_init(on_first, first_en, ready_at);
        check("on_first_cycle", on_first, 1);
        check("first_en_rise", first_en, 22);
        check("ready_after_init", ready_at, 122);
        check("init_done_set", 32'(o_init_done), 32'h1);
        check_init_log();

        log_q.delete();
        send(1'b1, 8'h41, busy, bad);
        check("char41_busy", busy, 18);
        check("char41_waveform", bad, 0);
        check("char41_pulse_count", log_q.size(), 1);
        if (log_q.size() > 0)
            check("char41_pulse", 32'(log_q[0]), 32'({1'b1, 1'b1, 8'h41, 16'(PULSE)}));

        send(1'b0, 8'h01, busy, bad);
        check("clear_busy", busy, 48);
        check("clear_waveform", bad, 0);
        send(1'b1, 8'h01, busy, bad);
        check("char01_busy", busy, 18);
        check("char01_waveform", bad, 0);
        send(1'b0, 8'h02, busy, bad);
        check("home_busy", busy, 48);
        send(1'b0, 8'h03, busy, bad);
        check("home_alt_busy", busy, 48);
        send(1'b0, 8'h04, busy, bad);
        check("cmd04_busy", busy, 18);
        send(1'b0, 8'h00, busy, bad);
        check("cmd00_busy", busy, 18);
        check("init_done_sticky", 32'(o_init_done), 32'h1);

        // Ignored pulse while busy, then a held request.
        log_q.delete();
        i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h44;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        i_valid = 1'b1; i_data = 8'h42;
        tick();
        i_valid = 1'b0;
        repeat (2) tick();
        i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h43;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 500) begin
            tick();
            guard++;
        end
        check("held_ready_seen", 32'(o_ready), 32'h1);
        tick();
        check("held_ready_one_cycle", 32'(o_ready), 32'h0);
        i_valid = 1'b0;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 500) begin
            tick();
            guard++;
        end
        tick();
        check("held_pulse_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("held_first_byte", 32'(log_q[0].data), 32'h44);
            check("held_second_byte", 32'(log_q[1].data), 32'h43);
        end

        // Reset while EN is high.
        i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h55;
        tick();
        i_valid = 1'b0;
        repeat (SETUP) tick();
        check("en_high_before_reset", 32'(o_io_lcd[10]), 32'h1);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_reset_io_lcd", o_io_lcd, 32'h0);
        check("async_reset_ready", 32'(o_ready), 32'h0);
        check("async_reset_init_done", 32'(o_init_done), 32'h0);
        tick();
        log_q.delete();
        i_reset = 1'b1;
        measure_init(on_first, first_en, ready_at);
        check("re_on_first_cycle", on_first, 1);
        check("re_first_en_rise", first_en, 22);
        check("re_ready_after_init", ready_at, 122);
        check("re_init_done_set", 32'(o_init_done), 32'h1);
        check_init_log();

        // Random stream with in-order scoreboard.
        log_q.delete();
        accepted = 0;
        guard = 0;
        while (accepted < 200 && guard < 40000) begin
            v    = ($urandom_range(0, 3) != 0);
            r_rs = 1'($urandom_range(0, 1));
            r_d  = 8'($urandom_range(0, 255));
            i_valid = v;
            i_rs    = r_rs;
            i_data  = r_d;
            if (v && o_ready === 1'b1) begin
                exp_q.push_back({r_rs, r_d});
                accepted++;
            end
            tick();
            guard++;
        end
        i_valid = 1'b0;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 500) begin
            tick();
            guard++;
        end
        tick();
        check("random_accepted", accepted, 200);
        check("random_pulse_count", log_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= log_q.size()) begin
                mism++;
            end else if (log_q[i].rs !== exp_q[i][8] || log_q[i].data !== exp_q[i][7:0] ||
                         log_q[i].width !== 16'(PULSE) || log_q[i].stable !== 1'b1) begin
                mism++;
            end
        end
        check("random_scoreboard", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
